counter_sync_reset: RTL and testbench

COUNTER_SYNC_RESET -- requirements
Module: counter_sync_reset

---
 rtl/counter_sync_reset.sv | 59 +++++
 tb/tb_counter_sync_reset.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/counter_sync_reset.sv
// Free-running SIZE-bit up-counter with a one-cycle WRAP pulse on all-ones -> zero.
// Optional synchronous CLEAR input, enabled by defining COUNTER_SYNC_CLEAR_EN.
module counter_sync_reset #(
    parameter int SIZE = 8
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            ENABLE,
`ifdef COUNTER_SYNC_CLEAR_EN
    input  logic            CLEAR,
`endif
    output logic [SIZE-1:0] VALUE,
    output logic            WRAP
);

    if (SIZE < 1 || SIZE > 32) begin : g_bad_size
        $error("counter_sync_reset: SIZE must be in 1..32");
    end

    logic [SIZE-1:0] value_q, value_d;
    logic            wrap_q, wrap_d;
    logic [SIZE:0]   sum;

    // The carry out of the MSB is the wrap indication; nothing else consumes it.
    assign sum = {1'b0, value_q} + {{SIZE{1'b0}}, 1'b1};

    always_comb begin
        value_d = value_q;
        wrap_d  = 1'b0;
`ifdef COUNTER_SYNC_CLEAR_EN
        if (CLEAR) begin
            value_d = '0;
            wrap_d  = 1'b0;
        end else if (ENABLE) begin
            value_d = sum[SIZE-1:0];
            wrap_d  = sum[SIZE];
        end
`else
        if (ENABLE) begin
            value_d = sum[SIZE-1:0];
            wrap_d  = sum[SIZE];
        end
`endif
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            value_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            value_q <= value_d;
            wrap_q  <= wrap_d;
        end
    end

    assign VALUE = value_q;
    assign WRAP  = wrap_q;

endmodule

// File: tb/tb_counter_sync_reset.sv
// Directed bench for counter_sync_reset: an 8-bit instance and a 1-bit instance.
// CLEAR scenarios run only when COUNTER_SYNC_CLEAR_EN is defined.
module tb_counter_sync_reset;

    logic       CLK;
    logic       RESET;
    logic       ENABLE;
    logic       en1;
    logic       CLEAR;
    logic [7:0] VALUE;
    logic       WRAP;
    logic [0:0] value1;
    logic       wrap1;

    int checks   = 0;
    int failures = 0;

    counter_sync_reset #(.SIZE(8)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .ENABLE (ENABLE),
`ifdef COUNTER_SYNC_CLEAR_EN
        .CLEAR  (CLEAR),
`endif
        .VALUE  (VALUE),
        .WRAP   (WRAP)
    );

    counter_sync_reset #(.SIZE(1)) dut1 (
        .CLK    (CLK),
        .RESET  (RESET),
        .ENABLE (en1),
`ifdef COUNTER_SYNC_CLEAR_EN
        .CLEAR  (1'b0),
`endif
        .VALUE  (value1),
        .WRAP   (wrap1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET  = 1'b1;
        ENABLE = 1'b1;
        en1    = 1'b0;
        CLEAR  = 1'b0;
        #2;
        check("reset_async_value", {24'd0, VALUE}, 32'd0);
        check("reset_async_wrap", {31'd0, WRAP}, 32'd0);

        // ENABLE is ignored while reset is held
        step();
        step();
        check("reset_held_en_value", {24'd0, VALUE}, 32'd0);
        check("reset_held_en_wrap", {31'd0, WRAP}, 32'd0);

        RESET  = 1'b0;
        ENABLE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_value", {24'd0, VALUE}, 32'd0);
            check("idle_wrap", {31'd0, WRAP}, 32'd0);
        end

        // full lap: 1..255, 0 with WRAP, then 1
        ENABLE = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            step();
            check("lap_value", {24'd0, VALUE}, i % 256);
            check("lap_wrap", {31'd0, WRAP}, (i == 256) ? 32'd1 : 32'd0);
        end
        step();
        check("post_wrap_value", {24'd0, VALUE}, 32'd1);
        check("post_wrap_wrap", {31'd0, WRAP}, 32'd0);

        ENABLE = 1'b0;
        #3 RESET = 1'b1;
        #1;
        check("midcycle_reset_value", {24'd0, VALUE}, 32'd0);
        step();
        RESET  = 1'b0;

        // hold behaviour
        ENABLE = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("count_to_10", {24'd0, VALUE}, 32'd10);
        ENABLE = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_10", {24'd0, VALUE}, 32'd10);
        end
        ENABLE = 1'b1;
        step();
        check("reenable_11", {24'd0, VALUE}, 32'd11);

        for (int i = 0; i < 117; i++) step();
        check("count_to_128", {24'd0, VALUE}, 32'd128);
        #3 RESET = 1'b1;
        #1;
        check("async_reset_128_value", {24'd0, VALUE}, 32'd0);
        check("async_reset_128_wrap", {31'd0, WRAP}, 32'd0);
        step();
        check("reset_held_value", {24'd0, VALUE}, 32'd0);
        RESET = 1'b0;
        step();
        check("first_after_reset", {24'd0, VALUE}, 32'd1);

        // reset at 255 must not produce a WRAP pulse
        for (int i = 0; i < 254; i++) step();
        check("count_to_255", {24'd0, VALUE}, 32'd255);
        #3 RESET = 1'b1;
        #1;
        step();
        check("reset_at_255_wrap", {31'd0, WRAP}, 32'd0);
        check("reset_at_255_value", {24'd0, VALUE}, 32'd0);
        ENABLE = 1'b0;
        RESET  = 1'b0;

`ifdef COUNTER_SYNC_CLEAR_EN
        ENABLE = 1'b1;
        for (int i = 0; i < 200; i++) step();
        check("count_to_200", {24'd0, VALUE}, 32'd200);
        CLEAR = 1'b1;
        step();
        check("clear_over_enable_value", {24'd0, VALUE}, 32'd0);
        check("clear_over_enable_wrap", {31'd0, WRAP}, 32'd0);
        CLEAR = 1'b0;
        step();
        check("after_clear", {24'd0, VALUE}, 32'd1);
        for (int i = 0; i < 254; i++) step();
        check("clear_count_255", {24'd0, VALUE}, 32'd255);
        CLEAR = 1'b1;
        step();
        check("clear_at_255_value", {24'd0, VALUE}, 32'd0);
        check("clear_at_255_wrap", {31'd0, WRAP}, 32'd0);
        CLEAR  = 1'b0;
        ENABLE = 1'b0;
`endif

        // 1-bit counter toggles and pulses WRAP on each return to zero
        check("size1_start", {31'd0, value1}, 32'd0);
        en1 = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            check("size1_value", {31'd0, value1}, (i % 2 == 1) ? 32'd1 : 32'd0);
            check("size1_wrap", {31'd0, wrap1}, (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        en1 = 1'b0;
        step();
        check("size1_hold_value", {31'd0, value1}, 32'd0);
        check("size1_hold_wrap", {31'd0, wrap1}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
